// File: rtl/fuzz_wb_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// fuzz_wb_pkg
// Shared definitions for the fuzzer's Wishbone bridges (master and slave side).
//   state_t               : bridge bus-cycle state (IDLE / CYCLE / GAP)
//   TIMEOUT_RDATA_DEFAULT : read data returned on bus error or timeout
//   SEL_ALL_ONES          : all-ones byte-select source; each bridge slices off
//                           DATA_WIDTH/8 bits of it (covers buses up to 512 bits)
// ---------------------------------------------------------------------------
package fuzz_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CYCLE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_DEAD;

  localparam int          SEL_MAX_WIDTH = 64;
  localparam logic [SEL_MAX_WIDTH-1:0] SEL_ALL_ONES = '1;

endpackage

// File: rtl/fuzz_wb_master_bridge.sv
// ---------------------------------------------------------------------------
// fuzz_wb_master_bridge
// Turns the fuzz FSM's level-sensitive request interface into Wishbone classic
// single-beat cycles. A bus timeout guarantees that a hung slave cannot stall
// the fuzzer; errors and timeouts both complete the request with an error flag.
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   ext_master_req/we         : request strobe (level) and direction (1 = write)
//   ext_master_addr_read/write: address used for reads / writes
//   ext_master_wdata          : write data
//   ext_master_rdata          : last read data (TIMEOUT_RDATA on failure)
//   ext_master_read_done      : one-cycle read completion pulse
//   ext_master_write_done     : one-cycle write completion pulse
//   ext_master_err            : one-cycle pulse alongside done on failure
//   wb_*                      : Wishbone classic master port
//   busy                      : high whenever the bridge is not idle
//   txn_count, err_count      : saturating completed / failed transaction counts
// ---------------------------------------------------------------------------
module fuzz_wb_master_bridge
  import fuzz_wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = DATA_WIDTH'(TIMEOUT_RDATA_DEFAULT),
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ext_master_req,
  input  logic                    ext_master_we,
  input  logic [ADDR_WIDTH-1:0]   ext_master_addr_read,
  input  logic [ADDR_WIDTH-1:0]   ext_master_addr_write,
  input  logic [DATA_WIDTH-1:0]   ext_master_wdata,
  output logic [DATA_WIDTH-1:0]   ext_master_rdata,
  output logic                    ext_master_read_done,
  output logic                    ext_master_write_done,
  output logic                    ext_master_err,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    txn_count,
  output logic [CNT_WIDTH-1:0]    err_count
);

  localparam int                  SEL_W    = DATA_WIDTH / 8;
  localparam logic [SEL_W-1:0]    SEL_ONES = SEL_ALL_ONES[SEL_W-1:0];
  localparam int                  TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic [TMO_W-1:0]        r_tmo;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_read_done;
  logic                    r_write_done;
  logic                    r_err;
  logic                    r_cyc;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [SEL_W-1:0]        r_sel;
  logic                    r_busy;
  logic [CNT_WIDTH-1:0]    r_txn_count;
  logic [CNT_WIDTH-1:0]    r_err_count;

  // Error beats ack; a timeout only counts when the slave stayed silent.
  logic w_fail;
  logic w_finish;
  assign w_fail   = wb_err_i || (!wb_ack_i && (r_tmo == TMO_LAST));
  assign w_finish = w_fail || wb_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tmo        <= '0;
      r_rdata      <= '0;
      r_read_done  <= 1'b0;
      r_write_done <= 1'b0;
      r_err        <= 1'b0;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_busy       <= 1'b0;
      r_txn_count  <= '0;
      r_err_count  <= '0;
    end else begin
      // Completion flags are single-cycle pulses.
      r_read_done  <= 1'b0;
      r_write_done <= 1'b0;
      r_err        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (ext_master_req) begin
            r_state <= ST_CYCLE;
            r_busy  <= 1'b1;
            r_cyc   <= 1'b1;
            r_we    <= ext_master_we;
            r_adr   <= ext_master_we ? ext_master_addr_write : ext_master_addr_read;
            r_dat   <= ext_master_wdata;
            r_sel   <= SEL_ONES;
            r_tmo   <= '0;
          end
        end

        ST_CYCLE: begin
          if (w_finish) begin
            r_state      <= ST_GAP;
            // Return the bus to its idle (all-zero) image.
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_read_done  <= !r_we;
            r_write_done <= r_we;
            r_err        <= w_fail;
            if (!r_we) begin
              r_rdata <= w_fail ? TIMEOUT_RDATA : wb_dat_i;
            end
            if (r_txn_count != '1) begin
              r_txn_count <= r_txn_count + CNT_WIDTH'(1);
            end
            if (w_fail && (r_err_count != '1)) begin
              r_err_count <= r_err_count + CNT_WIDTH'(1);
            end
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        ST_GAP: begin
          // One mandatory dead cycle; a pending request is taken in IDLE.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

  assign ext_master_rdata      = r_rdata;
  assign ext_master_read_done  = r_read_done;
  assign ext_master_write_done = r_write_done;
  assign ext_master_err        = r_err;
  assign wb_cyc_o              = r_cyc;
  assign wb_stb_o              = r_cyc;
  assign wb_we_o               = r_we;
  assign wb_adr_o              = r_adr;
  assign wb_dat_o              = r_dat;
  assign wb_sel_o              = r_sel;
  assign busy                  = r_busy;
  assign txn_count             = r_txn_count;
  assign err_count             = r_err_count;

endmodule

// File: tb/tb_fuzz_wb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_fuzz_wb_master_bridge
// Directed bench for the Wishbone master bridge. Expected completions are
// queued when a request is issued and compared when done pulses appear.
// A small configurable Wishbone slave answers bus cycles.
// ---------------------------------------------------------------------------
module tb_fuzz_wb_master_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int CW  = 16;
  localparam logic [DW-1:0] BAD = 32'hDEAD_DEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ext_master_req = 1'b0;
  logic          ext_master_we = 1'b0;
  logic [AW-1:0] ext_master_addr_read = '0;
  logic [AW-1:0] ext_master_addr_write = '0;
  logic [DW-1:0] ext_master_wdata = '0;
  logic [DW-1:0] ext_master_rdata;
  logic          ext_master_read_done;
  logic          ext_master_write_done;
  logic          ext_master_err;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic          busy;
  logic [CW-1:0] txn_count;
  logic [CW-1:0] err_count;

  fuzz_wb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_RDATA(BAD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ext_master_req(ext_master_req), .ext_master_we(ext_master_we),
    .ext_master_addr_read(ext_master_addr_read),
    .ext_master_addr_write(ext_master_addr_write),
    .ext_master_wdata(ext_master_wdata), .ext_master_rdata(ext_master_rdata),
    .ext_master_read_done(ext_master_read_done),
    .ext_master_write_done(ext_master_write_done),
    .ext_master_err(ext_master_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy), .txn_count(txn_count), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic          is_read;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];

  int nchecks = 0;
  int nerrors = 0;
  int cyc_cnt = 0;
  int t0 = 0;
  int rd_done_cnt = 0;
  int wr_done_cnt = 0;
  int last_rd_cyc = 0;
  int hi_run = 0, last_hi_run = 0;
  int lo_run = 0, last_lo_run = 0;
  int exp_txn = 0, exp_errc = 0;

  // Slave configuration
  int            slv_delay = 0;
  bit            slv_never = 1'b0;
  bit            slv_err = 1'b0;
  bit            slv_addr_data = 1'b0;
  logic [DW-1:0] slv_data = '0;
  int            slv_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Wishbone slave: acks slv_delay cycles after the start of each bus cycle.
  initial forever begin
    @(negedge clk);
    if (!(wb_cyc_o && wb_stb_o)) begin
      slv_cnt  = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = '0;
    end else begin
      if (!slv_never && slv_cnt == slv_delay) begin
        wb_ack_i = 1'b1;
        wb_err_i = slv_err;
        wb_dat_i = slv_addr_data ? (wb_adr_o ^ 32'h1111_0000) : slv_data;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
      slv_cnt++;
    end
  end

  // Bus-cycle length and gap tracker.
  initial forever begin
    @(negedge clk);
    if (wb_cyc_o) begin
      if (lo_run > 0) begin
        last_lo_run = lo_run;
        lo_run = 0;
      end
      hi_run++;
    end else begin
      if (hi_run > 0) begin
        last_hi_run = hi_run;
        hi_run = 0;
      end
      lo_run++;
    end
  end

  // Completion monitor / scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    check("done_exclusive", {63'd0, ext_master_read_done & ext_master_write_done}, 64'd0);
    check("err_implies_done",
          {63'd0, ext_master_err & ~(ext_master_read_done | ext_master_write_done)}, 64'd0);
    if (ext_master_read_done || ext_master_write_done) begin
      if (ext_master_read_done) begin
        rd_done_cnt++;
        last_rd_cyc = cyc_cnt;
      end else begin
        wr_done_cnt++;
      end
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_kind", {63'd0, ext_master_read_done}, {63'd0, e.is_read});
        check("sb_err", {63'd0, ext_master_err}, {63'd0, e.err});
        if (e.is_read) check("sb_rdata", {32'd0, ext_master_rdata}, {32'd0, e.rdata});
      end
    end
  end

  task automatic wait_cyc(input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_cyc_o === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input string tag, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int delay, input bit never,
                         input bit err_mode, input bit exp_err, input logic [DW-1:0] exp_rdata);
    exp_t e;
    bit ok;
    slv_delay = delay;
    slv_never = never;
    slv_err   = err_mode;
    slv_addr_data = 1'b0;
    e.is_read = !we;
    e.err     = exp_err;
    e.rdata   = exp_rdata;
    sb.push_back(e);
    ext_master_we = we;
    if (we) ext_master_addr_write = addr;
    else    ext_master_addr_read  = addr;
    ext_master_wdata = wdata;
    ext_master_req   = 1'b1;
    t0 = cyc_cnt;
    wait_cyc(1'b1, ok);
    check({tag, "_accept"}, {63'd0, ok}, 64'd1);
    ext_master_req = 1'b0;
    check({tag, "_adr"}, {32'd0, wb_adr_o}, {32'd0, addr});
    check({tag, "_we"}, {63'd0, wb_we_o}, {63'd0, we});
    check({tag, "_stb"}, {63'd0, wb_stb_o}, 64'd1);
    check({tag, "_sel"}, {60'd0, wb_sel_o}, 64'hF);
    if (we) check({tag, "_dat_o"}, {32'd0, wb_dat_o}, {32'd0, wdata});
    wait_idle(ok);
    check({tag, "_idle"}, {63'd0, ok}, 64'd1);
    exp_txn++;
    if (exp_err) exp_errc++;
    check({tag, "_txn_count"}, {48'd0, txn_count}, exp_txn);
    check({tag, "_err_count"}, {48'd0, err_count}, exp_errc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int rd0;
    exp_t e;

    // Reset state
    #1;
    check("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rdata", {32'd0, ext_master_rdata}, 64'd0);
    check("rst_txn", {48'd0, txn_count}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write with 3 wait states
    run_txn("wr1", 1'b1, 32'h3000_0000, 32'hA000_0111, 3, 1'b0, 1'b0, 1'b0, '0);
    check("wr1_wr_done_cnt", wr_done_cnt, 64'd1);

    // Zero-wait read: read_done two edges after the request edge
    slv_data = 32'h63A9_1243;
    run_txn("rd1", 1'b0, 32'h4000_0010, '0, 0, 1'b0, 1'b0, 1'b0, 32'h63A9_1243);
    check("rd1_latency", last_rd_cyc - t0, 64'd2);
    check("rd1_rdata", {32'd0, ext_master_rdata}, 64'h63A9_1243);

    // A write leaves rdata untouched
    run_txn("wr2", 1'b1, 32'h3000_0004, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b0, '0);
    check("rdata_held", {32'd0, ext_master_rdata}, 64'h63A9_1243);

    // Back-to-back reads with req held
    rd0 = rd_done_cnt;
    slv_delay = 1;
    slv_never = 1'b0;
    slv_err   = 1'b0;
    slv_addr_data = 1'b1;
    e.is_read = 1'b1; e.err = 1'b0; e.rdata = 32'h5111_0000;
    sb.push_back(e);
    e.rdata = 32'h5111_0004;
    sb.push_back(e);
    ext_master_we = 1'b0;
    ext_master_addr_read = 32'h4000_0000;
    ext_master_req = 1'b1;
    wait_cyc(1'b1, ok);
    check("b2b_first_accept", {63'd0, ok}, 64'd1);
    check("b2b_first_adr", {32'd0, wb_adr_o}, 64'h4000_0000);
    ext_master_addr_read = 32'h4000_0004;
    @(negedge clk);
    check("b2b_adr_stable", {32'd0, wb_adr_o}, 64'h4000_0000);
    wait_cyc(1'b0, ok);
    check("b2b_first_end", {63'd0, ok}, 64'd1);
    wait_cyc(1'b1, ok);
    check("b2b_second_accept", {63'd0, ok}, 64'd1);
    ext_master_req = 1'b0;
    check("b2b_second_adr", {32'd0, wb_adr_o}, 64'h4000_0004);
    check("b2b_gap", last_lo_run, 64'd2);
    wait_idle(ok);
    check("b2b_idle", {63'd0, ok}, 64'd1);
    check("b2b_done_cnt", rd_done_cnt - rd0, 64'd2);
    exp_txn += 2;
    check("b2b_txn_count", {48'd0, txn_count}, exp_txn);

    // Timeout on a silent slave
    run_txn("tmo", 1'b0, 32'h4000_0020, '0, 0, 1'b1, 1'b0, 1'b1, BAD);
    check("tmo_cyc_len", last_hi_run, TMO);
    check("tmo_rdata", {32'd0, ext_master_rdata}, {32'd0, BAD});

    // ack and err together: error wins
    slv_data = 32'h0BAD_F00D;
    run_txn("ackerr", 1'b0, 32'h4000_0030, '0, 0, 1'b0, 1'b1, 1'b1, BAD);

    // Asynchronous reset in the middle of a bus cycle
    slv_never = 1'b1;
    ext_master_we = 1'b1;
    ext_master_addr_write = 32'h3000_0100;
    ext_master_req = 1'b1;
    wait_cyc(1'b1, ok);
    check("rstmid_accept", {63'd0, ok}, 64'd1);
    ext_master_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_cyc", {63'd0, wb_cyc_o}, 64'd0);
    check("rstmid_stb", {63'd0, wb_stb_o}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_txn", {48'd0, txn_count}, 64'd0);
    check("rstmid_err", {48'd0, err_count}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_txn = 0;
    exp_errc = 0;
    @(negedge clk);
    run_txn("wr_after_rst", 1'b1, 32'h3000_0200, 32'hCAFE_0001, 0, 1'b0, 1'b0, 1'b0, '0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/fuzz_wb_master_bridge.md
Name: fuzz_wb_master_bridge

Overview:
- Downstream of the central fuzz FSM. Converts its simple request interface (req/we/addr_read/addr_write/wdata) into Wishbone classic single-beat bus cycles on the fuzzer's external master port.
- Returns read_done/write_done pulses and read data to the FSM.
- Adds a bus timeout, error reporting and saturating transaction/error counters so a hung or erroring IP never deadlocks the fuzzer.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, maximum cycles in a bus cycle before abort; must be ≥2.
- TIMEOUT_RDATA, 32'hDEADDEAD, read data returned on timeout or bus error.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ext_master_req  in  1  request, level-sensitive
- ext_master_we  in  1  1 = write, 0 = read
- ext_master_addr_read  in  ADDR_WIDTH  read address
- ext_master_addr_write  in  ADDR_WIDTH  write address
- ext_master_wdata  in  DATA_WIDTH  write data
- ext_master_rdata  out  DATA_WIDTH  last read data
- ext_master_read_done  out  1  one-cycle pulse, read complete
- ext_master_write_done  out  1  one-cycle pulse, write complete
- ext_master_err  out  1  one-cycle pulse with done, transaction failed
- wb_cyc_o  out  1  Wishbone CYC
- wb_stb_o  out  1  Wishbone STB
- wb_we_o  out  1  Wishbone WE
- wb_adr_o  out  ADDR_WIDTH  Wishbone address
- wb_dat_o  out  DATA_WIDTH  Wishbone write data
- wb_sel_o  out  DATA_WIDTH/8  byte selects, always all ones during a cycle
- wb_dat_i  in  DATA_WIDTH  Wishbone read data
- wb_ack_i  in  1  Wishbone ACK
- wb_err_i  in  1  Wishbone ERR
- busy  out  1  high whenever state ≠ IDLE
- txn_count  out  CNT_WIDTH  completed transactions, saturating
- err_count  out  CNT_WIDTH  failed transactions (err or timeout), saturating

Behaviour:
- All outputs are registered.
- Reset clears every output to 0, state to IDLE, and the timeout counter to 0. ext_master_rdata resets to 0.
- States: IDLE, CYCLE, GAP.
- IDLE, req=1 at edge N:
  - Capture we.
  - Capture address: addr_write if we=1, else addr_read.
  - Capture wdata.
  - From N+1: wb_cyc_o=wb_stb_o=1, wb_we_o=we, wb_sel_o all ones, timeout counter cleared. Go to CYCLE.
- IDLE, req=0: remain in IDLE; Wishbone outputs 0.
- CYCLE: address, data and we held stable; timeout counter increments each cycle.
  - ack_i=1 and err_i=0 at edge M:
    - cyc/stb drop after edge M.
    - The matching done pulse is high for cycle M+1.
    - Reads: wb_dat_i is latched into ext_master_rdata at edge M.
    - txn_count increments. Go to GAP.
  - err_i=1 (with or without ack): error wins.
    - cyc/stb drop.
    - Matching done and ext_master_err pulse.
    - Reads: rdata = TIMEOUT_RDATA.
    - txn_count and err_count both increment. Go to GAP.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no ack/err: handled identically to err.
- GAP: exactly one cycle with cyc=stb=0, then IDLE. req is ignored in GAP. A req still held by the FSM is accepted in the following IDLE cycle. Minimum spacing between transactions is therefore 2 idle bus cycles.
- Read latency with zero-wait-state slave (ack in first CYCLE cycle): req at edge N → read_done high in cycle N+2.
- ext_master_rdata holds its value until the next read completion. Writes never modify it.
- Changes to req/addr/wdata while in CYCLE are ignored.
- Counters saturate at all-ones and never wrap.
- Async reset mid-CYCLE: cyc/stb fall immediately and no done pulse is issued.
- read_done and write_done are never high together.

Decomposition:
- Shared package fuzz_wb_pkg holds:
  - the state enum (IDLE/CYCLE/GAP);
  - the TIMEOUT_RDATA default;
  - the byte-select all-ones helper constant, shared with the slave-side bridge.
- No sub-module: the timeout counter and the status counters are inline.

Test Plan:
- Write: req=1, we=1, addr_write=0x3000_0000, wdata=0xA0000111; slave acks 3 cycles after stb.
  - Wishbone: adr=0x3000_0000, dat_o=0xA0000111, we=1, sel=0xF.
  - One write_done pulse, err=0, txn_count=1.
- Read: req=1, we=0, addr_read=0x4000_0010; slave acks in the first cycle with dat_i=0x63A91243.
  - read_done in cycle N+2; ext_master_rdata=0x63A91243 and held afterwards.
- Back-to-back reads: req held for 0x4000_0000 then 0x4000_0004.
  - Two distinct bus cycles with a 2-cycle gap.
  - Exactly two read_done pulses.
- Timeout: TIMEOUT_CYCLES=8, slave never acks.
  - cyc drops after 8 cycles.
  - read_done and ext_master_err pulse together; rdata=0xDEADDEAD; err_count=1.
- ack_i and err_i asserted in the same cycle:
  - Treated as error: err pulse, rdata=TIMEOUT_RDATA.
- Reset asserted mid-CYCLE:
  - cyc/stb/busy go 0 asynchronously with no done pulse; counters are 0.
  - After release, a new write completes normally.
